// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : State encodings and oversampling constants shared by the
//               UART receiver and transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_start = 2'd1;
    localparam logic [1:0] c_data  = 2'd2;
    localparam logic [1:0] c_stop  = 2'd3;

    localparam int c_overSample = 16;
    localparam int c_midBit     = 7;
    localparam int c_vote0      = 13;
    localparam int c_vote1      = 14;
    localparam int c_vote2      = 15;

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sync
// Description : Two-flop synchronizer for the serial line; resets to idle (1).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [1:0] r_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], d};
        end
    end

    assign q = r_sync[1];

endmodule
`default_nettype wire

// File: rtl/uart_rx_frame.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_frame
// Description : 16x oversampling UART receiver with 3-sample majority vote,
//               one word per frame with done strobe and framing-error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int dataBits  = 8,
    parameter int stopTicks = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic                rx,
    output logic [dataBits-1:0] dataOut,
    output logic                rxDone,
    output logic                frameErr
);

    // Stop-state counting may exceed one bit period, so the tick counter widens with it.
    localparam int c_tickW = (stopTicks > c_overSample) ? $clog2(stopTicks) : 4;

    localparam logic [c_tickW-1:0] c_tOne   = c_tickW'(1);
    localparam logic [c_tickW-1:0] c_tMid   = c_tickW'(c_midBit);
    localparam logic [c_tickW-1:0] c_tVote0 = c_tickW'(c_vote0);
    localparam logic [c_tickW-1:0] c_tVote1 = c_tickW'(c_vote1);
    localparam logic [c_tickW-1:0] c_tVote2 = c_tickW'(c_vote2);
    localparam logic [c_tickW-1:0] c_tStop0 = c_tickW'(stopTicks - 3);
    localparam logic [c_tickW-1:0] c_tStop1 = c_tickW'(stopTicks - 2);
    localparam logic [c_tickW-1:0] c_tStop2 = c_tickW'(stopTicks - 1);
    localparam logic [2:0]         c_lastBit = 3'(dataBits - 1);

    logic                w_rxS;
    logic                w_vote;
    logic [1:0]          r_state;
    logic [c_tickW-1:0]  r_numTick;
    logic [2:0]          r_numBits;
    logic [dataBits-1:0] r_shift;
    logic [1:0]          r_cap;
    logic                r_armed;
    logic [dataBits-1:0] r_dataOut;
    logic                r_rxDone;
    logic                r_frameErr;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (w_rxS)
    );

    // Third vote sample is the live line at the deciding tick.
    assign w_vote = (r_cap[0] & r_cap[1]) | (r_cap[0] & w_rxS) | (r_cap[1] & w_rxS);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= c_idle;
            r_numTick  <= '0;
            r_numBits  <= '0;
            r_shift    <= '0;
            r_cap      <= '0;
            r_armed    <= 1'b0;
            r_dataOut  <= '0;
            r_rxDone   <= 1'b0;
            r_frameErr <= 1'b0;
        end else begin
            r_rxDone <= 1'b0;
            case (r_state)
                c_idle: begin
                    // A line held low after a frame must go high before a new start counts.
                    if (w_rxS) begin
                        r_armed <= 1'b1;
                    end else if (r_armed) begin
                        r_armed   <= 1'b0;
                        r_numTick <= '0;
                        r_state   <= c_start;
                    end
                end
                c_start: begin
                    if (tick) begin
                        if (r_numTick == c_tMid) begin
                            if (!w_rxS) begin
                                r_numTick <= '0;
                                r_numBits <= '0;
                                r_state   <= c_data;
                            end else begin
                                r_state <= c_idle;
                            end
                        end else begin
                            r_numTick <= r_numTick + c_tOne;
                        end
                    end
                end
                c_data: begin
                    if (tick) begin
                        if (r_numTick == c_tVote0) r_cap[0] <= w_rxS;
                        if (r_numTick == c_tVote1) r_cap[1] <= w_rxS;
                        if (r_numTick == c_tVote2) begin
                            r_shift   <= {w_vote, r_shift[dataBits-1:1]};
                            r_numTick <= '0;
                            if (r_numBits == c_lastBit) begin
                                r_state <= c_stop;
                            end else begin
                                r_numBits <= r_numBits + 3'd1;
                            end
                        end else begin
                            r_numTick <= r_numTick + c_tOne;
                        end
                    end
                end
                c_stop: begin
                    if (tick) begin
                        if (r_numTick == c_tStop0) r_cap[0] <= w_rxS;
                        if (r_numTick == c_tStop1) r_cap[1] <= w_rxS;
                        if (r_numTick == c_tStop2) begin
                            r_dataOut  <= r_shift;
                            r_frameErr <= ~w_vote;
                            r_rxDone   <= 1'b1;
                            r_numTick  <= '0;
                            r_state    <= c_idle;
                        end else begin
                            r_numTick <= r_numTick + c_tOne;
                        end
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    assign dataOut  = r_dataOut;
    assign rxDone   = r_rxDone;
    assign frameErr = r_frameErr;

endmodule
`default_nettype wire

// File: doc/uart_rx_frame.md
# uart_rx_frame

Oversampling UART receiver; the receive-side counterpart of the FIFO-fed transmitter on the same serial link. Samples the asynchronous `rx` line on the shared 16x baud `tick` and validates the start bit mid-bit. Majority-votes each data and stop bit, then presents one parallel word per frame with a done strobe and a framing-error flag. The output feeds the receive FIFO write port.

## Interface
- `dataBits`, 8: data bits per frame, LSB first; legal 5..8.
- `stopTicks`, 16: ticks counted in the stop state; legal ≥16.
- `clk` in 1: single system clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-low; one clock; reset is asynchronous and active-low.
- `tick` in 1: one-`clk` pulse at 16x baud from the shared baud generator.
- `rx` in 1: asynchronous serial line, idle high.
- `dataOut` out `dataBits`: last received word, held until the next completed frame.
- `rxDone` out 1: one-cycle pulse, frame complete; FIFO write enable.
- `frameErr` out 1: stop bit sampled low in the last frame; valid with `rxDone`, held until the next `rxDone`.

## Operation
- `rx` passes through a 2-FF synchronizer, reset value 1; all logic uses the synchronized `rxS`.
- `armed` flag: set when `rxS`=1 in idle, cleared on leaving idle. A start is accepted only when `armed`=1. A held-low line (break) after a frame yields no further frames until `rx` returns high.
- States (2-bit): `idle`, `start`, `data`, `stop`. `numTick` is 4-bit, `numBits` is 3-bit.
- `idle`: if `armed` and `rxS`=0, go to `start` with `numTick`=0. No tick is required to leave idle.
- `start`: on each tick, `numTick`+1. At the tick where `numTick`=7 (start mid-bit):
  - if `rxS`=0: `numTick`←0, `numBits`←0, go to `data`;
  - else (glitch): go to `idle`, no output.
- `data`: on each tick, `numTick`+1. Capture `rxS` at the ticks where `numTick`=13, 14, 15. At `numTick`=15:
  - bit = majority of the three captures;
  - shift right, bit enters the MSB of the `dataBits` shift register;
  - `numTick`←0. If `numBits`=`dataBits`-1, go to `stop`; else `numBits`+1.
- `stop`: on each tick, `numTick`+1. Capture at `numTick` = `stopTicks`-3, -2, -1 (mod 16 wrap not permitted; `numTick` width grows with `stopTicks`). At `stopTicks`-1:
  - `dataOut`←shift register;
  - `frameErr`←NOT majority;
  - `rxDone`←1 for one cycle;
  - go to `idle`.
- A frame with a framing error is still delivered; the consumer decides whether to drop it.
- Ticks are ignored in `idle`. Non-tick cycles change nothing except the synchronizer, `armed`, and the idle→start transition.

## Timing
- Reset (async, active-low): state `idle`, counters 0, shift register 0, `dataOut`=0, `rxDone`=0, `frameErr`=0, synchronizer=1, `armed`=0.
- Reset deasserted mid-frame: no partial word is emitted; the bits in flight are lost.
- `rx` falling edge to state `start`: 3 `clk` (2 sync + 1 state).
- `rxDone`, `dataOut` and `frameErr` are registered and update in the same cycle: the cycle after the final stop-state tick.
- `rxDone` is never asserted on consecutive cycles.
- A new start edge can be detected 1 cycle after `rxDone` if `rx` is already high then low.
- No back-pressure: the consumer must accept `rxDone` unconditionally. `dataOut` stays stable for at least one frame time.

## Structure
- Shared package `uart_pkg`: state encodings (`idle`, `start`, `data`, `stop`), the oversample constant 16, the mid-bit index 7, and the vote indices 13..15. These are shared with the transmitter.
- One sub-module, `uart_rx_sync`: 2-FF synchronizer with an async active-low reset to 1.
- Majority vote is inline combinational logic (`a&b | a&c | b&c`).

## Test plan
- Frame 0x55, stop=1, 16 ticks/bit → one `rxDone`, `dataOut`=0x55, `frameErr`=0; `rxDone` lands the cycle after the 16th stop-state tick.
- Back-to-back 0xA3 then 0x0F with no idle gap → two `rxDone` pulses; 0xA3 then 0x0F; frame spacing 10 bit-times.
- Start pulse low for 4 ticks, then high → no `rxDone`, FSM back in `idle` after tick 7.
- Frame 0xC9 with stop bit low, then line held low 3 bit-times, then high, then frame 0x12:
  - `dataOut`=0xC9, `frameErr`=1;
  - no spurious frame during the break;
  - 0x12 received with `frameErr`=0.
- Frame 0x81 with a 1-tick inverted glitch at `numTick`=14 of bit 0 → majority rejects the glitch; `dataOut`=0x81.
- `reset` asserted during bit 4 of 0x3C, released, then 0x3C sent cleanly:
  - outputs at reset values during reset;
  - exactly one `rxDone` afterward, `dataOut`=0x3C.
